// File: rtl/multi_phase_discharge_sequencer_if.sv
// Command/status bundle between the control front end and the discharge sequencer.
interface multi_phase_discharge_sequencer_if #(
  parameter int unsigned N_CH = 2,
  parameter int unsigned TW   = 16
);
  logic            start;
  logic            stop;
  logic            single_mode;
  logic            single_fire;
  logic            cfg_valid;
  logic [TW-1:0]   cfg_ton;
  logic [TW-1:0]   cfg_toff;
  logic [N_CH-1:0] cfg_ch_en;
  logic [15:0]     sample_voltage;
  logic [15:0]     sample_current;
  logic [N_CH-1:0] mosfet_hi;
  logic [N_CH-1:0] mosfet_lo;
  logic            mosfet_deion;
  logic            is_operation;
  logic            is_breakdown;
  logic            fault_oc;
  logic [15:0]     pulse_count;
  logic [15:0]     open_count;

  // Controller side: issues commands and samples, observes gates and status
  modport master (
    output start, stop, single_mode, single_fire, cfg_valid, cfg_ton, cfg_toff, cfg_ch_en,
           sample_voltage, sample_current,
    input  mosfet_hi, mosfet_lo, mosfet_deion, is_operation, is_breakdown, fault_oc,
           pulse_count, open_count
  );

  // Sequencer side
  modport slave (
    input  start, stop, single_mode, single_fire, cfg_valid, cfg_ton, cfg_toff, cfg_ch_en,
           sample_voltage, sample_current,
    output mosfet_hi, mosfet_lo, mosfet_deion, is_operation, is_breakdown, fault_oc,
           pulse_count, open_count
  );
endinterface

// File: rtl/multi_phase_discharge_sequencer.sv
// EDM gap-cycle sequencer: round-robin buck phases, breakdown detect, Ton/dead/Toff timing,
// over-current trip and pulse statistics. Outputs are registered from the next state so the
// gates switch on the same edge the state does.
module multi_phase_discharge_sequencer #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned TW        = 16,
  parameter int unsigned DEAD_TIME = 12,
  parameter int unsigned WAIT_MIN  = 300,
  parameter int unsigned WAIT_MAX  = 10000,
  parameter int unsigned BD_VOL    = 40,
  parameter int unsigned BD_TIME   = 70,
  parameter int unsigned MAX_CUR   = 120
) (
  input logic clk,
  input logic rst,
  multi_phase_discharge_sequencer_if.slave bus
);

  localparam int unsigned PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned BW = $clog2(BD_TIME + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BD, S_DISCHARGE, S_DEAD, S_TOFF, S_FAULT
  } state_t;

  state_t          st, st_n;
  logic [TW-1:0]   tmr;
  logic [TW-1:0]   ton_sh, toff_sh, ton_act, toff_act;
  logic [N_CH-1:0] ch_en_sh;
  logic [PW-1:0]   ptr, ptr_n;
  logic [BW-1:0]   bd_cnt, bd_cnt_n;
  logic [N_CH-1:0] phase_sel;
  logic            below, over, fire, gates_on;
  logic            load_act, inc_pulse, inc_open, set_fault, clr_fault;

  // First enabled phase found scanning cyclically from 'from' (optionally skipping 'from' itself)
  function automatic logic [PW-1:0] scan_en(input logic [PW-1:0] from,
                                            input logic [N_CH-1:0] mask,
                                            input logic skip_self);
    logic [PW-1:0] res;
    logic          found;
    int unsigned   idx;
    res   = from;
    found = 1'b0;
    for (int unsigned k = 0; k <= N_CH; k++) begin
      idx = (32'(from) + k) % N_CH;
      if (!found && !(skip_self && k == 0) && |(mask & (N_CH'(1) << idx))) begin
        res   = PW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Next-state decode and transition strobes
  always_comb begin
    st_n      = st;
    ptr_n     = ptr;
    load_act  = 1'b0;
    inc_pulse = 1'b0;
    inc_open  = 1'b0;
    set_fault = 1'b0;
    clr_fault = 1'b0;
    below     = bus.sample_voltage < 16'(BD_VOL);
    over      = bus.sample_current > 16'(MAX_CUR);
    fire      = bus.single_mode ? bus.single_fire : bus.start;
    bd_cnt_n  = below ? ((bd_cnt == BW'(BD_TIME)) ? bd_cnt : bd_cnt + BW'(1)) : '0;

    case (st)
      S_IDLE: begin
        if (!bus.stop && fire && (ch_en_sh != '0)) begin
          st_n     = S_WAIT_BD;
          ptr_n    = scan_en(ptr, ch_en_sh, 1'b0);
          load_act = 1'b1;
        end
      end
      S_WAIT_BD: begin
        if (bus.stop) begin
          st_n = S_IDLE;
        end else if (over) begin
          st_n      = S_FAULT;
          set_fault = 1'b1;
        end else if (bd_cnt_n == BW'(BD_TIME) && tmr >= TW'(WAIT_MIN)) begin
          st_n = S_DISCHARGE;
        end else if (tmr == TW'(WAIT_MAX - 1)) begin
          st_n     = S_DEAD;
          inc_open = 1'b1;
        end
      end
      S_DISCHARGE: begin
        if (bus.stop) begin
          st_n = S_IDLE;
        end else if (over) begin
          st_n      = S_FAULT;
          set_fault = 1'b1;
        end else if (tmr == ton_act - TW'(1)) begin
          st_n      = S_DEAD;
          inc_pulse = 1'b1;
        end
      end
      S_DEAD: begin
        if (bus.stop) begin
          st_n = S_IDLE;
        end else if (tmr == TW'(DEAD_TIME - 1)) begin
          st_n = S_TOFF;
        end
      end
      S_TOFF: begin
        if (bus.stop) begin
          st_n = S_IDLE;
        end else if (tmr == toff_act - TW'(1)) begin
          ptr_n = scan_en(ptr, ch_en_sh, 1'b1);
          if (bus.single_mode || ch_en_sh == '0) begin
            st_n = S_IDLE;
          end else begin
            st_n     = S_WAIT_BD;
            load_act = 1'b1;
          end
        end
      end
      S_FAULT: begin
        // A stop also acknowledges the trip so the block never sits in IDLE with a fault flag
        if (bus.start || bus.stop) begin
          st_n      = S_IDLE;
          clr_fault = 1'b1;
        end
      end
      default: st_n = S_IDLE;
    endcase

    phase_sel = N_CH'(1) << ptr_n;
    gates_on  = (st_n == S_WAIT_BD) || (st_n == S_DISCHARGE);
  end

  // State, timers, shadow/active config, statistics and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st               <= S_IDLE;
      tmr              <= '0;
      bd_cnt           <= '0;
      ptr              <= '0;
      ton_sh           <= TW'(1);
      toff_sh          <= TW'(1);
      ton_act          <= TW'(1);
      toff_act         <= TW'(1);
      ch_en_sh         <= '0;
      bus.mosfet_hi    <= '0;
      bus.mosfet_lo    <= '0;
      bus.mosfet_deion <= 1'b0;
      bus.is_operation <= 1'b0;
      bus.is_breakdown <= 1'b0;
      bus.fault_oc     <= 1'b0;
      bus.pulse_count  <= '0;
      bus.open_count   <= '0;
    end else begin
      st     <= st_n;
      ptr    <= ptr_n;
      tmr    <= (st_n != st) ? '0 : tmr + TW'(1);
      bd_cnt <= (st == S_WAIT_BD && st_n == S_WAIT_BD) ? bd_cnt_n : '0;

      // Zero durations are stored as one cycle
      if (bus.cfg_valid) begin
        ton_sh   <= (bus.cfg_ton == '0) ? TW'(1) : bus.cfg_ton;
        toff_sh  <= (bus.cfg_toff == '0) ? TW'(1) : bus.cfg_toff;
        ch_en_sh <= bus.cfg_ch_en;
      end
      if (load_act) begin
        ton_act  <= ton_sh;
        toff_act <= toff_sh;
      end

      if (inc_pulse) bus.pulse_count <= bus.pulse_count + 16'd1;
      if (inc_open)  bus.open_count  <= bus.open_count + 16'd1;
      if (set_fault)      bus.fault_oc <= 1'b1;
      else if (clr_fault) bus.fault_oc <= 1'b0;

      bus.mosfet_hi    <= gates_on ? phase_sel : '0;
      bus.mosfet_lo    <= gates_on ? phase_sel : '0;
      bus.mosfet_deion <= (st_n == S_TOFF);
      bus.is_operation <= (st_n != S_IDLE) && (st_n != S_FAULT);
      bus.is_breakdown <= (st_n == S_DISCHARGE);
    end
  end

endmodule
